alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle multiplier that sequences the shared combinational ALU through shift-and-add iterations. It owns the ALU's operand and operation inputs: during a multiply it drives the ALU itself, and when idle it passes the execute stage's request straight through. It returns the low N bits of the product, which are identical for signed and unsigned operands. It sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

## Interface
- `N`, 32: datapath width; must match the ALU's `N`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  multiply request; sampled only in IDLE.
- `op_a`  in  N  multiplicand, latched when `start` is accepted.
- `op_b`  in  N  multiplier, latched when `start` is accepted.
- `ext_input1`  in  N  pass-through operand 1 from the execute stage.
- `ext_input2`  in  N  pass-through operand 2 from the execute stage.
- `ext_operation`  in  4  pass-through ALU opcode.
- `alu_input1`  out  N  drives ALU `input1`.
- `alu_input2`  out  N  drives ALU `input2`.
- `alu_operation`  out  4  drives ALU `operation`.
- `alu_result`  in  N  ALU `result`, combinational in the same cycle.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `product` is valid.
- `product`  out  N  low N bits of `op_a*op_b`; registered and held until the next accepted `start`.

## Operation
- Registers:
  - `acc` (N bits)
  - `mcand` (N bits)
  - `mplier` (N bits)
  - `cnt` ($clog2(N)+1 bits)
  - `state`
- States: IDLE, ADD, SHL, DONE.
- IDLE:
  - ALU ports mirror `ext_*` combinationally.
  - On `start`: `mcand<=op_a`, `mplier<=op_b`, `acc<=0`, `cnt<=0`, then go to ADD.
- ADD:
  - Drive ALU op 4'b0000 (add) with `acc`, `mcand`.
  - If `mplier[0]`, then `acc<=alu_result`; otherwise `acc` holds.
  - Go to SHL.
- SHL:
  - Drive ALU op 4'b0110 (logical shift left) with `mcand`, 1; `mcand<=alu_result`.
  - `mplier<=mplier>>1`, `cnt<=cnt+1`.
  - If `cnt==N-1`, go to DONE; otherwise go to ADD.
- DONE:
  - `product<=acc` on entry, so it is visible in DONE.
  - `done=1`.
  - ALU ports drive `ext_*`.
  - Go to IDLE next cycle.
- `start` outside IDLE is ignored; there is no queueing.
- During ADD and SHL the `ext_*` inputs are not forwarded. The ALU result seen by the pipeline is meaningless then, and the pipeline must stall on `busy`.
- Only opcodes 4'b0000 and 4'b0110 are ever issued internally, so the ALU's hold-on-default path is never exercised by this block.
- Arithmetic is modulo 2^N; overflow is discarded silently.
- Reset values:
  - `state`=IDLE
  - `busy`=0
  - `done`=0
  - `product`=0
  - `acc`, `mcand`, `mplier`, `cnt` = 0
  - ALU ports = `ext_*`
- Reset asserted mid-multiply returns to IDLE on the next edge. No `done` is issued and `product` clears to 0.

## Timing
- `start` is accepted at edge t (state IDLE).
- Cycles t+1 .. t+2N alternate ADD, SHL.
- Cycle t+2N+1: DONE, with `done`=1 and `product` valid.
- Cycle t+2N+2: IDLE, `busy`=0; a new `start` is accepted in this cycle.
- Default N=32: `done` at t+65, with `busy` high for 65 cycles.
- `done` and `busy` are both registered-state decodes with no combinational path from `start`.
- ALU port muxing is combinational from `state` and `ext_*`.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In IDLE, `start` with `op_b==0` goes directly to DONE, with `product`=0 at t+1.
  - In SHL, if the shifted `mplier` is 0, go to DONE regardless of `cnt`.
  - Latency becomes 2k+1 cycles, where k = index of the highest set bit of `op_b` plus 1.
- Undefined: fixed latency of 2N+1 cycles for all operands.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode localparams `ALU_ADD`=4'b0000 and `ALU_SLL`=4'b0110, plus the remaining opcodes for the execute stage.
  - State encoding for this block.
- No sub-module. The ALU is instantiated outside this block, next to it, so it stays one shared instance. This block only drives its ports.

## Test plan
- N=32, `op_a`=5, `op_b`=3, one-cycle `start` → `done` at t+65 with `product`=15; `busy` high t+1..t+65.
- `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → `product`=0x00000001 (signed -1*-1); `op_a`=0x00010000, `op_b`=0x00010000 → `product`=0.
- `ext_operation`=4'b0001, `ext_input1`=9, `ext_input2`=4 while idle → `alu_result`=5 in the same cycle. During a multiply, `alu_operation` only ever shows 0000 or 0110.
- A second `start` pulse at t+10 with `op_a`=7 → ignored; original `product` delivered at t+65, and no second `done`.
- `reset` at t+20 mid-multiply → IDLE at t+21, `busy`=0, `product`=0, and no `done` ever seen.
- With `MUL_EARLY_EXIT_EN`:
  - `op_b`=1, `op_a`=6 → `done` at t+3 with `product`=6.
  - `op_b`=0 → `done` at t+1 with `product`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: ALU opcodes and multiplier sequencer states.
// Imported by the ALU, the multiplier sequencer and the execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_ADD  = 2'd1,
    MUL_SHL  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencing the shared ALU; low N bits of the product.
// MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic [N-1:0] ext_input1,
  input  logic [N-1:0] ext_input2,
  input  logic [3:0]   ext_operation,
  output logic [N-1:0] alu_input1,
  output logic [N-1:0] alu_input2,
  output logic [3:0]   alu_operation,
  input  logic [N-1:0] alu_result,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_e  state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  product_q, product_d;
  logic [N-1:0]  mplier_shr;

  assign mplier_shr = mplier_q >> 1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL_ADD;
`ifdef MUL_EARLY_EXIT_EN
          if (op_b == '0) begin
            state_d   = MUL_DONE;
            product_d = '0;
          end
`endif
        end
      end
      MUL_ADD: begin
        if (mplier_q[0]) acc_d = alu_result;
        state_d = MUL_SHL;
      end
      MUL_SHL: begin
        mcand_d  = alu_result;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CW'(1);
        state_d  = MUL_ADD;
        if (cnt_q == CNT_LAST) state_d = MUL_DONE;
`ifdef MUL_EARLY_EXIT_EN
        if (mplier_shr == '0) state_d = MUL_DONE;
`endif
        // acc is final here: SHL never touches it
        if (state_d == MUL_DONE) product_d = acc_q;
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  always_comb begin
    alu_input1    = ext_input1;
    alu_input2    = ext_input2;
    alu_operation = ext_operation;
    unique case (state_q)
      MUL_ADD: begin
        alu_input1    = acc_q;
        alu_input2    = mcand_q;
        alu_operation = ALU_ADD;
      end
      MUL_SHL: begin
        alu_input1    = mcand_q;
        alu_input2    = N'(1);
        alu_operation = ALU_SLL;
      end
      default: begin
        alu_input1    = ext_input1;
        alu_input2    = ext_input2;
        alu_operation = ext_operation;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MUL_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != MUL_IDLE);
  assign done    = (state_q == MUL_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU closing the loop.
// Build with +define+MUL_EARLY_EXIT_EN to exercise the early-exit variant.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] ext_input1, ext_input2;
  logic [3:0]  ext_operation;
  logic [31:0] alu_input1, alu_input2;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        busy, done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  alu_mul_seq #(.N(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op_a(op_a),
    .op_b(op_b),
    .ext_input1(ext_input1),
    .ext_input2(ext_input2),
    .ext_operation(ext_operation),
    .alu_input1(alu_input1),
    .alu_input2(alu_input2),
    .alu_operation(alu_operation),
    .alu_result(alu_result),
    .busy(busy),
    .done(done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0000: alu_result = alu_input1 + alu_input2;
      4'b0001: alu_result = alu_input1 - alu_input2;
      4'b0110: alu_result = alu_input1 << alu_input2[4:0];
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return (b == 0) ? 1 : 2 * k + 1;
`else
    return 65;
`endif
  endfunction

  task automatic run_mul(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p,
                         input int glitch);
    int   cyc;
    logic op_ok, busy_ok;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h5555_AAAA;
    cyc = 1;
    op_ok = 1'b1;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (alu_operation != 4'b0000 && alu_operation != 4'b0110)
        op_ok = 1'b0;
      if (cyc == glitch) begin
        start = 1'b1;
        op_a  = 32'd7;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat(b)));
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_prod"}, product, p);
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    chk({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_alu_op_run"}, {31'b0, op_ok}, 32'd1);
    chk({tag, "_pass_done"}, {28'b0, alu_operation}, {28'b0, ext_operation});
    tick();
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idle_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_held"}, product, p);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      tick();
    end
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    ext_input1 = 32'd9;
    ext_input2 = 32'd4;
    ext_operation = 4'b0001;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_prod", product, 32'd0);
    chk("rst_in1", alu_input1, 32'd9);
    reset = 1'b0;
    tick();
    chk("pass_op", {28'b0, alu_operation}, 32'd1);
    chk("pass_in2", alu_input2, 32'd4);
    chk("pass_res", alu_result, 32'd5);

    run_mul("m5x3", 32'd5, 32'd3, 32'd15, 0);
    run_mul("mneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_mul("movf", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
    run_mul("m6x1", 32'd6, 32'd1, 32'd6, 0);
    run_mul("mx0", 32'd1234, 32'd0, 32'd0, 0);
    run_mul("mbig", 32'h1234_5678, 32'h9ABC_DEF1,
            32'h1234_5678 * 32'h9ABC_DEF1, 0);
    run_mul("mign", 32'd5, 32'h8000_0000, 32'h8000_0000, 9);
    no_done("mign_nodone", 70);

    op_a  = 32'd5;
    op_b  = 32'h8000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("mrst_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_prod", product, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    no_done("mrst_nodone", 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
